// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared, externally supplied ALU.
// A single transaction is in flight at a time: accept, execute for one cycle, hold the response.
module alu_arbiter #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [7:0]     req_op,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [1:0]     req_flag,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_err,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic           alu_flag,
  output logic [3:0]     alu_ctrl,
  input  logic [N-1:0]   alu_result,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic           last_q;
  logic           owner_q;
  logic           illegal_q;

  logic           gnt_d;
  logic [3:0]     op_d;
  logic [N-1:0]   a_d;
  logic [N-1:0]   b_d;
  logic           flag_d;
  logic           hs;

  // A tie goes to the requester that was not served last; a lone request always wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    if (valid == 2'b11) return ~last;
    return valid[1];
  endfunction

  always_comb begin
    gnt_d     = rr_pick(req_valid, last_q);
    op_d      = gnt_d ? req_op[7:4]       : req_op[3:0];
    a_d       = gnt_d ? req_a[2*N-1:N]    : req_a[N-1:0];
    b_d       = gnt_d ? req_b[2*N-1:N]    : req_b[N-1:0];
    flag_d    = gnt_d ? req_flag[1]       : req_flag[0];
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid != 2'b00) begin
      req_ready = gnt_d ? 2'b10 : 2'b01;
    end
  end

  assign hs   = |req_ready;
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      illegal_q  <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_flag   <= 1'b0;
      alu_ctrl   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            owner_q   <= gnt_d;
            illegal_q <= op_d[3];
            // Illegal opcodes never reach the ALU; its inputs keep the previous operation.
            if (!op_d[3]) begin
              alu_ctrl <= op_d;
              alu_a    <= a_d;
              alu_b    <= b_d;
              alu_flag <= flag_d;
            end
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= illegal_q ? '0 : alu_result;
          rsp_err    <= illegal_q;
          rsp_valid  <= owner_q ? 2'b10 : 2'b01;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid <= 2'b00;
            last_q    <= owner_q;
            state_q   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors then random traffic, checked by a
// transaction-level predictor feeding a response scoreboard.
module tb_alu_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [7:0]     req_op;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [1:0]     req_flag;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [N-1:0]   rsp_result;
  logic           rsp_err;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic           alu_flag;
  logic [3:0]     alu_ctrl;
  logic [N-1:0]   alu_result;
  logic           busy;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flag(req_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_flag(alu_flag), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU semantics: and, or, add+carry, inc, dec, not, sub-borrow, xor.
  function automatic logic [N-1:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic f);
    logic [N-1:0] fx;
    fx = {{(N-1){1'b0}}, f};
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b + fx;
      4'd3:    return a + 1'b1;
      4'd4:    return a - 1'b1;
      4'd5:    return ~a;
      4'd6:    return a - b - fx;
      4'd7:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b, alu_flag);

  typedef struct {
    logic [1:0]   vld;
    logic [N-1:0] res;
    logic         err;
    int           due;
  } rsp_t;

  rsp_t sb_q[$];
  int   acc_log[$];
  int   own_log[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predictor state: at most one pending transaction, response due two cycles after accept.
  bit           m_pend = 1'b0;
  int           m_acc = 0;
  logic         m_own = 1'b0;
  logic         m_last = 1'b1;
  logic [3:0]   m_ctrl = 4'd0;
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_b = '0;
  logic         m_flag = 1'b0;
  logic         rst_prev = 1'b0;
  logic [1:0]   exp_rdy, exp_rv;
  logic         g;
  logic [3:0]   p_op;
  logic [N-1:0] p_a, p_b;
  logic         p_f;
  rsp_t         item;

  always @(negedge clk) begin
    if (arm) begin
      exp_rv = 2'b00;
      if (m_pend && cyc >= m_acc + 2) exp_rv = m_own ? 2'b10 : 2'b01;
      exp_rdy = 2'b00;
      g = 1'b0;
      if (!m_pend && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("busy", 32'(busy), 32'(m_pend));
      check("alu_outputs", 32'({alu_ctrl, alu_a, alu_b, alu_flag}),
            32'({m_ctrl, m_a, m_b, m_flag}));
      if (rst_prev) check("rsp_after_reset", 32'({rsp_result, rsp_err}), 32'(0));
      if (!rst && (req_ready & req_valid) != 2'b00) begin
        acc_log.push_back(cyc);
        own_log.push_back(req_ready[1] ? 1 : 0);
      end
      if (rst) begin
        m_pend = 1'b0; m_last = 1'b1;
        m_ctrl = 4'd0; m_a = '0; m_b = '0; m_flag = 1'b0;
        sb_q.delete();
      end else if (exp_rdy != 2'b00) begin
        p_op = g ? req_op[7:4] : req_op[3:0];
        p_a  = g ? req_a[2*N-1:N] : req_a[N-1:0];
        p_b  = g ? req_b[2*N-1:N] : req_b[N-1:0];
        p_f  = g ? req_flag[1] : req_flag[0];
        item.vld = exp_rdy;
        item.res = p_op[3] ? '0 : alu_fn(p_op, p_a, p_b, p_f);
        item.err = p_op[3];
        item.due = cyc + 2;
        sb_q.push_back(item);
        m_pend = 1'b1; m_acc = cyc; m_own = g;
        if (!p_op[3]) begin
          m_ctrl = p_op; m_a = p_a; m_b = p_b; m_flag = p_f;
        end
      end else if (exp_rv != 2'b00 && rsp_ready[m_own]) begin
        m_pend = 1'b0;
        m_last = m_own;
      end
      rst_prev = rst;
    end
  end

  // Response monitor: pops an expectation when a response first appears, then holds it.
  rsp_t cur;
  bit   have_cur = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (arm) begin
      if (rsp_valid != 2'b00) begin
        if (!have_cur) begin
          if (sb_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL rsp_unexpected: got rsp_valid %0b expected none (cycle %0d)", rsp_valid, cyc);
          end else begin
            cur = sb_q.pop_front();
            have_cur = 1'b1;
            check("rsp_latency", 32'(cyc), 32'(cur.due));
          end
        end
        if (have_cur) begin
          check("rsp_owner", 32'(rsp_valid), 32'(cur.vld));
          check("rsp_result", 32'(rsp_result), 32'(cur.res));
          check("rsp_err", 32'(rsp_err), 32'(cur.err));
        end
      end else begin
        have_cur = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic f);
    if (id == 0) begin
      req_op[3:0] = op; req_a[N-1:0] = a; req_b[N-1:0] = b; req_flag[0] = f;
    end else begin
      req_op[7:4] = op; req_a[2*N-1:N] = a; req_b[2*N-1:N] = b; req_flag[1] = f;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0;
    req_flag = 2'b00; rsp_ready = 2'b00;
    step();
    arm = 1'b1;
    step(); step();
    check("reset_outputs",
          32'({req_ready, rsp_valid, rsp_result, rsp_err, busy, alu_a, alu_b, alu_flag, alu_ctrl}),
          32'(0));
    rst = 1'b0;

    // req0 add with carry: 5 + 9 + 1
    set_req(0, 4'd2, 4'd5, 4'd9, 1'b1); req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("exec_alu_ctrl", 32'(alu_ctrl), 32'd2);
    step();
    check("t2_rsp_valid", 32'(rsp_valid), 32'b01);
    check("t2_rsp_result", 32'(rsp_result), 32'hF);
    check("t2_rsp_err", 32'(rsp_err), 32'd0);
    // Hold the response with both requesters waiting
    set_req(1, 4'd1, 4'd3, 4'd4, 1'b0); req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_rsp_valid", 32'(rsp_valid), 32'b01);
      check("hold_rsp_result", 32'(rsp_result), 32'hF);
      check("hold_req_ready", 32'(req_ready), 32'b00);
      check("hold_busy", 32'(busy), 32'd1);
    end
    req_valid = 2'b00; rsp_ready = 2'b10;
    step();
    check("non_owner_ready_ignored", 32'(rsp_valid), 32'b01);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b11;

    // req1 add wrapping: F + 1
    set_req(1, 4'd2, 4'hF, 4'd1, 1'b0); req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    check("wrap_rsp_valid", 32'(rsp_valid), 32'b10);
    check("wrap_rsp_result", 32'(rsp_result), 32'd0);
    step();

    // illegal opcode from req0
    set_req(0, 4'd9, 4'd3, 4'd4, 1'b1); req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("illegal_alu_ctrl_held", 32'(alu_ctrl), 32'd2);
    step();
    check("illegal_rsp_err", 32'(rsp_err), 32'd1);
    check("illegal_rsp_result", 32'(rsp_result), 32'd0);
    step();

    // reset during EXEC discards the transaction
    set_req(0, 4'd1, 4'd6, 4'd3, 1'b0); req_valid = 2'b01;
    step();
    req_valid = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state",
          32'({rsp_valid, busy, rsp_result, rsp_err, alu_ctrl, alu_a}), 32'(0));
    repeat (4) step();

    // round robin under continuous contention
    rst = 1'b1;
    step();
    rst = 1'b0;
    acc_log.delete(); own_log.delete();
    set_req(0, 4'd7, 4'd10, 4'd12, 1'b0);
    set_req(1, 4'd6, 4'd2, 4'd5, 1'b1);
    req_valid = 2'b11; rsp_ready = 2'b11;
    repeat (12) step();
    req_valid = 2'b00;
    check("rr_accept_count", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("rr_owner", 32'(own_log[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("rr_spacing", 32'(acc_log[i] - acc_log[i-1]), 32'd3);
    end
    repeat (3) step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      req_valid = 2'($urandom);
      req_op    = 8'($urandom);
      req_a     = (2*N)'($urandom);
      req_b     = (2*N)'($urandom);
      req_flag  = 2'($urandom);
      rsp_ready = 2'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (6) step();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
